// File: rtl/clock_time_core_if.sv
// Handshake/status bundle between the timekeeping core and its controller/formatter.
// The master side drives the controls; the core (slave) drives time and scan outputs.
interface clock_time_core_if;
  logic        run_en;
  logic        clear;
  logic        btn_sec;
  logic        btn_min;
  logic [11:0] data_show;
  logic [2:0]  byte_status;
  logic        sec_tick;
  logic        hour_wrap;

  modport master (
    output run_en, clear, btn_sec, btn_min,
    input  data_show, byte_status, sec_tick, hour_wrap
  );

  modport slave (
    input  run_en, clear, btn_sec, btn_min,
    output data_show, byte_status, sec_tick, hour_wrap
  );
endinterface

// File: rtl/clock_time_core.sv
// MM:SS timekeeper with debounced set buttons and a free-running 8-phase digit scan.
// Feeds the 7-segment formatter with a packed time word and the current scan phase.
module clock_time_core #(
  parameter int TICK_DIV = 10000000,
  parameter int SCAN_DIV = 10000,
  parameter int DEBOUNCE = 200000
) (
  input logic              clock,
  input logic              reset,
  clock_time_core_if.slave bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  logic [TW-1:0] presc_reg;
  logic [SW-1:0] scan_cnt_reg;
  logic [2:0]    phase_reg;
  logic [5:0]    sec_reg;
  logic [5:0]    min_reg;
  logic          sec_tick_reg;
  logic          hour_wrap_reg;

  logic [1:0] btn_raw;
  logic [1:0] btn_rise;
  logic       tick;
  logic       set_sec;
  logic       set_min;

  assign btn_raw = {bus.btn_min, bus.btn_sec};

  // Per-button: 2-flop synchroniser, then a level filter that only flips after
  // DEBOUNCE consecutive disagreeing samples. The rise is flagged in the same
  // cycle the filtered level is about to go high, so each press counts once.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic          sync1_reg;
      logic          sync2_reg;
      logic          level_reg;
      logic [DW-1:0] cnt_reg;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          level_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg != level_reg) begin
            if (cnt_reg == DB_LAST) begin
              level_reg <= sync2_reg;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign btn_rise[gi] = sync2_reg && !level_reg && (cnt_reg == DB_LAST);
    end
  endgenerate

  assign tick    = bus.run_en && (presc_reg == TICK_LAST);
  // Edges that land while running are simply lost; a held button cannot re-fire later.
  assign set_sec = btn_rise[0] && !bus.run_en;
  assign set_min = btn_rise[1] && !bus.run_en;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_reg     <= '0;
      sec_reg       <= '0;
      min_reg       <= '0;
      sec_tick_reg  <= 1'b0;
      hour_wrap_reg <= 1'b0;
    end else begin
      sec_tick_reg  <= 1'b0;
      hour_wrap_reg <= 1'b0;
      if (bus.clear) begin
        presc_reg <= '0;
        sec_reg   <= '0;
        min_reg   <= '0;
      end else begin
        if (bus.run_en) begin
          presc_reg <= tick ? '0 : presc_reg + 1'b1;
        end
        if (tick) begin
          sec_tick_reg <= 1'b1;
          sec_reg      <= inc60(sec_reg);
          if (sec_reg == 6'd59) begin
            min_reg <= inc60(min_reg);
            if (min_reg == 6'd59) begin
              hour_wrap_reg <= 1'b1;
            end
          end
        end else begin
          // Set mode: fields roll independently, no carry and no pulses.
          if (set_sec) begin
            sec_reg <= inc60(sec_reg);
          end
          if (set_min) begin
            min_reg <= inc60(min_reg);
          end
        end
      end
    end
  end

  // Scan phase runs on its own; neither run_en nor clear touches it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt_reg <= '0;
      phase_reg    <= '0;
    end else if (scan_cnt_reg == SCAN_LAST) begin
      scan_cnt_reg <= '0;
      phase_reg    <= phase_reg + 3'd1;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 1'b1;
    end
  end

  assign bus.data_show   = {min_reg, sec_reg};
  assign bus.byte_status = phase_reg;
  assign bus.sec_tick    = sec_tick_reg;
  assign bus.hour_wrap   = hour_wrap_reg;

endmodule

// File: tb/tb_clock_time_core.sv
// Directed bench for clock_time_core with small dividers (tick 4, scan 2, debounce 3).
module tb_clock_time_core;
  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   n_tick;
  int   n_wrap;
  int   edge_cnt;
  int   base_tick;
  int   base_wrap;
  logic [2:0] exp_phase;

  clock_time_core_if bus();

  clock_time_core #(.TICK_DIV(4), .SCAN_DIV(2), .DEBOUNCE(3)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.sec_tick)  n_tick <= n_tick + 1;
    if (bus.hour_wrap) n_wrap <= n_wrap + 1;
  end

  // Edges since the last reset release; the scan phase is a pure function of it.
  always @(posedge clock or negedge reset) begin
    if (!reset) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press(input logic s, input logic m, input int hold);
    bus.btn_sec = s;
    bus.btn_min = m;
    step(hold);
    bus.btn_sec = 1'b0;
    bus.btn_min = 1'b0;
    step(8);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_tick = 0; n_wrap = 0;
    reset = 1'b0;
    bus.run_en = 1'b0; bus.clear = 1'b0; bus.btn_sec = 1'b0; bus.btn_min = 1'b0;
    step(2);
    chk("rst_data", int'(bus.data_show), 0);
    chk("rst_phase", int'(bus.byte_status), 0);
    chk("rst_tick", int'(bus.sec_tick), 0);
    chk("rst_wrap", int'(bus.hour_wrap), 0);

    // Reset mid-count
    reset = 1'b1; bus.run_en = 1'b1;
    step(3);
    chk("t1_no_tick_yet", int'(bus.sec_tick), 0);
    step(1);
    chk("t1_first_tick", int'(bus.sec_tick), 1);
    chk("t1_data_1", int'(bus.data_show), 1);
    step(8);
    chk("t1_data_3", int'(bus.data_show), 3);
    #2 reset = 1'b0;
    #1;
    chk("t1_async_data", int'(bus.data_show), 0);
    chk("t1_async_tick", int'(bus.sec_tick), 0);
    chk("t1_async_phase", int'(bus.byte_status), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    step(3);
    chk("t1_rel_no_tick", int'(bus.sec_tick), 0);
    step(1);
    chk("t1_rel_tick", int'(bus.sec_tick), 1);
    chk("t1_rel_data", int'(bus.data_show), 1);

    // Minute carry over 240 cycles
    bus.clear = 1'b1;
    step(1);
    chk("t2_clear", int'(bus.data_show), 0);
    bus.clear = 1'b0;
    base_tick = n_tick; base_wrap = n_wrap;
    step(240);
    chk("t2_data", int'(bus.data_show), 'h040);
    bus.run_en = 1'b0;
    @(negedge clock); #1;
    chk("t2_tick_count", n_tick - base_tick, 60);
    chk("t2_no_wrap", n_wrap - base_wrap, 0);
    step(1);

    // Debounce: glitches rejected, holds give one increment each
    base_tick = n_tick; base_wrap = n_wrap;
    press(1'b1, 1'b0, 1);
    chk("t4_glitch1", int'(bus.data_show), 'h040);
    press(1'b1, 1'b0, 2);
    chk("t4_glitch2", int'(bus.data_show), 'h040);
    press(1'b1, 1'b0, 3);
    chk("t4_hold3", int'(bus.data_show), 'h041);
    press(1'b1, 1'b0, 100);
    chk("t4_hold100", int'(bus.data_show), 'h042);
    for (int i = 0; i < 57; i++) press(1'b1, 1'b0, 4);
    chk("t4_sec59", int'(bus.data_show), 'h07B);
    press(1'b1, 1'b0, 4);
    chk("t4_sec_wrap_nocarry", int'(bus.data_show), 'h040);
    for (int i = 0; i < 58; i++) press(1'b1, 1'b1, 4);
    chk("t4_both", int'(bus.data_show), 'hEFA);
    press(1'b0, 1'b1, 4);
    chk("t4_min_wrap", int'(bus.data_show), 'h03A);
    for (int i = 0; i < 59; i++) press(1'b0, 1'b1, 4);
    press(1'b1, 1'b0, 4);
    chk("t4_5959", int'(bus.data_show), 'hEFB);
    chk("t4_set_no_tick", n_tick - base_tick, 0);
    chk("t4_set_no_wrap", n_wrap - base_wrap, 0);

    // Hour wrap by tick
    bus.run_en = 1'b1;
    step(3);
    chk("t3_hold", int'(bus.data_show), 'hEFB);
    chk("t3_no_tick", int'(bus.sec_tick), 0);
    step(1);
    chk("t3_data", int'(bus.data_show), 0);
    chk("t3_tick", int'(bus.sec_tick), 1);
    chk("t3_wrap", int'(bus.hour_wrap), 1);
    bus.run_en = 1'b0;
    step(1);
    chk("t3_tick_1cyc", int'(bus.sec_tick), 0);
    chk("t3_wrap_1cyc", int'(bus.hour_wrap), 0);

    // Clear colliding with a tick
    bus.run_en = 1'b1;
    step(3);
    bus.clear = 1'b1;
    step(1);
    chk("t5_data", int'(bus.data_show), 0);
    chk("t5_tick_blocked", int'(bus.sec_tick), 0);
    bus.clear = 1'b0;
    step(3);
    chk("t5_no_tick", int'(bus.sec_tick), 0);
    step(1);
    chk("t5_next_tick", int'(bus.sec_tick), 1);
    chk("t5_next_data", int'(bus.data_show), 1);

    // Press while running is discarded, even if run_en drops while still held
    bus.run_en = 1'b0; bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    bus.run_en = 1'b1; bus.btn_sec = 1'b1;
    step(20);
    chk("t4_run_ticks", int'(bus.data_show), 5);
    bus.run_en = 1'b0;
    step(10);
    bus.btn_sec = 1'b0;
    step(10);
    chk("t4_run_press_dropped", int'(bus.data_show), 5);

    // Scan sequence undisturbed by run_en/clear activity
    for (int i = 0; i < 32; i++) begin
      if (i % 3 == 0) bus.run_en = ~bus.run_en;
      bus.clear = (i % 5 == 0);
      step(1);
      exp_phase = 3'((edge_cnt / 2) % 8);
      chk("t6_phase", int'(bus.byte_status), int'(exp_phase));
    end
    bus.clear = 1'b0; bus.run_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
